// File: rtl/wb8_tc_responder.sv
// wb8_tc_responder: 8-bit Wishbone-classic slave around a 16-bit timer/counter with compare
// toggle output and level IRQ. Defining WB8_TC_CAPTURE_EN adds synchronized input capture on tc_ic.
module wb8_tc_responder #(
  parameter logic [7:0]  PRESC_RST = 8'h00,
  parameter logic [15:0] TOP_RST   = 16'hFFFF,
  parameter logic [15:0] CMP_RST   = 16'hFFFF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       wb_cyc_i,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  input  logic [7:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_ack_o,
  input  logic       tc_ic,
  output logic       tc_oc,
  output logic       tc_int
);

  localparam logic [3:0] A_CTRL   = 4'h0;
  localparam logic [3:0] A_PRESC  = 4'h1;
  localparam logic [3:0] A_TOP_L  = 4'h2;
  localparam logic [3:0] A_TOP_H  = 4'h3;
  localparam logic [3:0] A_CMP_L  = 4'h4;
  localparam logic [3:0] A_CMP_H  = 4'h5;
  localparam logic [3:0] A_CNT_L  = 4'h6;
  localparam logic [3:0] A_CNT_H  = 4'h7;
  localparam logic [3:0] A_CAP_L  = 4'h8;
  localparam logic [3:0] A_CAP_H  = 4'h9;
  localparam logic [3:0] A_STATUS = 4'hA;

  logic        access, wr, rd;
  logic [3:0]  adr;
  logic [3:0]  unused_adr;
  logic [7:0]  rd_data;
  logic        en, oc_en, ie_ovf, ie_cmp, ie_cap;
  logic [7:0]  presc, presc_cnt;
  logic [15:0] top, cmp, cnt, cap;
  logic [7:0]  cnt_h_shadow;
  logic [2:0]  status, status_set, status_clr;
  logic        clr_wr, tick, wrap, ovf_set, cmp_set, cap_evt;

  // A held strobe is only accepted while ack is low, so each ack retires exactly one access.
  assign access     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr         = access & wb_we_i;
  assign rd         = access & ~wb_we_i;
  assign adr        = wb_adr_i[3:0];
  assign unused_adr = wb_adr_i[7:4];

  always_comb begin
    rd_data = 8'h00;
    case (adr)
      A_CTRL:   rd_data = {2'b00, ie_cap, 1'b0, ie_cmp, ie_ovf, oc_en, en};
      A_PRESC:  rd_data = presc;
      A_TOP_L:  rd_data = top[7:0];
      A_TOP_H:  rd_data = top[15:8];
      A_CMP_L:  rd_data = cmp[7:0];
      A_CMP_H:  rd_data = cmp[15:8];
      A_CNT_L:  rd_data = cnt[7:0];
      A_CNT_H:  rd_data = cnt_h_shadow;
      A_CAP_L:  rd_data = cap[7:0];
      A_CAP_H:  rd_data = cap[15:8];
      A_STATUS: rd_data = {5'b00000, status};
      default:  rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 8'h00;
    end else begin
      wb_ack_o <= access;
      if (access) wb_dat_o <= wb_we_i ? 8'h00 : rd_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      en     <= 1'b0;
      oc_en  <= 1'b0;
      ie_ovf <= 1'b0;
      ie_cmp <= 1'b0;
      presc  <= PRESC_RST;
      top    <= TOP_RST;
      cmp    <= CMP_RST;
    end else if (wr) begin
      case (adr)
        A_CTRL: begin
          en     <= wb_dat_i[0];
          oc_en  <= wb_dat_i[1];
          ie_ovf <= wb_dat_i[2];
          ie_cmp <= wb_dat_i[3];
        end
        A_PRESC: presc      <= wb_dat_i;
        A_TOP_L: top[7:0]   <= wb_dat_i;
        A_TOP_H: top[15:8]  <= wb_dat_i;
        A_CMP_L: cmp[7:0]   <= wb_dat_i;
        A_CMP_H: cmp[15:8]  <= wb_dat_i;
        default: ;
      endcase
    end
  end

  // >= rather than == so a PRESC lowered below the running prescaler still ticks promptly.
  assign clr_wr  = wr && (adr == A_CTRL) && wb_dat_i[4];
  assign tick    = en && (presc_cnt >= presc) && !clr_wr;
  assign wrap    = (cnt == top) || (cnt == 16'hFFFF);
  assign ovf_set = tick && wrap;
  assign cmp_set = tick && (cnt == cmp);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc_cnt <= 8'h00;
      cnt       <= 16'h0000;
      tc_oc     <= 1'b0;
    end else if (clr_wr) begin
      presc_cnt <= 8'h00;
      cnt       <= 16'h0000;
    end else if (en) begin
      if (tick) begin
        presc_cnt <= 8'h00;
        cnt       <= wrap ? 16'h0000 : cnt + 16'h0001;
        if (cmp_set && oc_en) tc_oc <= ~tc_oc;
      end else begin
        presc_cnt <= presc_cnt + 8'h01;
      end
    end
  end

  // Hardware sets are OR-ed in after the W1C mask so a same-edge set survives the clear.
  assign status_set = {cap_evt, cmp_set, ovf_set};
  assign status_clr = (wr && (adr == A_STATUS)) ? wb_dat_i[2:0] : 3'b000;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status       <= 3'b000;
      tc_int       <= 1'b0;
      cnt_h_shadow <= 8'h00;
    end else begin
      status <= (status & ~status_clr) | status_set;
      tc_int <= |(status & {ie_cap, ie_cmp, ie_ovf});
      if (rd && (adr == A_CNT_L)) cnt_h_shadow <= cnt[15:8];
    end
  end

`ifdef WB8_TC_CAPTURE_EN
  // ic_sync[1:0] is the synchronizer; ic_sync[2] is history for rising-edge detection.
  logic [2:0] ic_sync;
  logic       ie_cap_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ic_sync  <= 3'b000;
      cap      <= 16'h0000;
      ie_cap_q <= 1'b0;
    end else begin
      ic_sync <= {ic_sync[1:0], tc_ic};
      if (cap_evt) cap <= cnt;
      if (wr && (adr == A_CTRL)) ie_cap_q <= wb_dat_i[5];
    end
  end

  assign cap_evt = ic_sync[1] & ~ic_sync[2];
  assign ie_cap  = ie_cap_q;
`else
  logic unused_ic;
  assign unused_ic = tc_ic;
  assign cap_evt   = 1'b0;
  assign cap       = 16'h0000;
  assign ie_cap    = 1'b0;
`endif

endmodule

// File: tb/tb_wb8_tc_responder.sv
// Directed bench for wb8_tc_responder: bus handshake, register map, timer wrap/compare,
// W1C priority, atomic CNT read and capture (either build of WB8_TC_CAPTURE_EN).
module tb_wb8_tc_responder;
  logic       clk = 1'b0;
  logic       resetn, cyc, stb, we, ic;
  logic [7:0] adr, dat_w, dat_r;
  logic       ack, oc, irq;
  logic [7:0] x;
  logic [3:0] pat;
  logic [7:0] first_dat;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  wb8_tc_responder dut (
    .clk(clk), .resetn(resetn),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(dat_w),
    .wb_dat_o(dat_r), .wb_ack_o(ack),
    .tc_ic(ic), .tc_oc(oc), .tc_int(irq)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one access on the first negedge with ack low; returns 1 time unit after the commit edge.
  task automatic bus(input logic w, input logic [7:0] a, input logic [7:0] d, output logic [7:0] q);
    @(negedge clk);
    for (int i = 0; i < 4 && ack; i++) @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d;
    @(posedge clk); #1;
    chk("ack", ack, 1'b1);
    q = dat_r;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] q;
    bus(1'b1, a, d, q);
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [15:0] exp);
    logic [7:0] q;
    bus(1'b0, a, 8'h00, q);
    chk(tag, q, exp);
  endtask

  initial begin
    resetn = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 8'h00; dat_w = 8'h00; ic = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", ack, 1'b0);
    chk("rst_dat", dat_r, 8'h00);
    chk("rst_oc", oc, 1'b0);
    chk("rst_int", irq, 1'b0);
    @(negedge clk) resetn = 1'b1;
    rd("rst_ctrl", 8'h00, 8'h00);
    rd("rst_presc", 8'h01, 8'h00);
    rd("rst_top_l", 8'h02, 8'hFF);
    rd("rst_top_h", 8'h03, 8'hFF);
    rd("rst_cmp_l", 8'h04, 8'hFF);
    rd("rst_cmp_h", 8'h05, 8'hFF);
    rd("rst_cnt_l", 8'h06, 8'h00);
    rd("rst_status", 8'h0A, 8'h00);

    // Handshake and map
    wr(8'h01, 8'h03);
    rd("presc_rb", 8'h01, 8'h03);
    rd("presc_alias", 8'hF1, 8'h03);
    rd("unmapped", 8'h0F, 8'h00);
    wr(8'h06, 8'h55);
    rd("cnt_ro", 8'h06, 8'h00);
    @(posedge clk);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h01;
    chk("ack_pre", ack, 1'b0);
    pat = 4'b0000;
    first_dat = 8'h00;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      pat[3-i] = ack;
      if (i == 0) first_dat = dat_r;
    end
    cyc = 1'b0; stb = 1'b0;
    chk("held_stb_acks", pat, 4'b1010);
    chk("held_stb_dat", first_dat, 8'h03);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h01; dat_w = 8'h77;
    #2 cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    chk("dropped_stb", ack, 1'b0);
    rd("dropped_no_wr", 8'h01, 8'h03);

    // Wrap at TOP=9, OVF, IRQ lag, W1C
    wr(8'h02, 8'd9);
    wr(8'h03, 8'h00);
    wr(8'h01, 8'h00);
    wr(8'h00, 8'h05);
    repeat (9) @(posedge clk);
    #1 chk("int_before_ovf", irq, 1'b0);
    @(posedge clk); #1;
    chk("int_lag", irq, 1'b0);
    @(posedge clk); #1;
    chk("int_after_ovf", irq, 1'b1);
    rd("status_ovf", 8'h0A, 8'h01);
    rd("cnt_after_wrap", 8'h06, 8'h03);
    wr(8'h0A, 8'h01);
    chk("int_w1c_lag", irq, 1'b1);
    @(posedge clk); #1;
    chk("int_w1c", irq, 1'b0);
    wr(8'h00, 8'h10);
    wr(8'h0A, 8'h07);
    rd("clr_cnt", 8'h06, 8'h00);

    // Compare toggle with PRESC=1
    wr(8'h04, 8'd5);
    wr(8'h05, 8'h00);
    wr(8'h01, 8'h01);
    wr(8'h00, 8'h0B);
    repeat (11) @(posedge clk);
    #1 chk("oc_before", oc, 1'b0);
    @(posedge clk); #1;
    chk("oc_toggle1", oc, 1'b1);
    chk("int_cmp_lag", irq, 1'b0);
    @(posedge clk); #1;
    chk("int_cmp", irq, 1'b1);
    repeat (18) @(posedge clk);
    #1 chk("oc_hold", oc, 1'b1);
    @(posedge clk); #1;
    chk("oc_toggle2", oc, 1'b0);
    rd("status_cmp", 8'h0A, 8'h03);
    wr(8'h00, 8'h10);
    wr(8'h0A, 8'h07);

    // Hardware set beats W1C on the same edge
    wr(8'h01, 8'h00);
    wr(8'h02, 8'd3);
    wr(8'h00, 8'h01);
    repeat (7) @(posedge clk);
    #1 wr(8'h0A, 8'h01);
    wr(8'h00, 8'h10);
    rd("set_wins", 8'h0A, 8'h01);
    wr(8'h0A, 8'h01);
    rd("w1c_plain", 8'h0A, 8'h00);

    // Atomic 16-bit CNT read across 0x00FF -> 0x0100
    wr(8'h02, 8'hFF);
    wr(8'h03, 8'hFF);
    wr(8'h00, 8'h01);
    repeat (255) @(posedge clk);
    #1 rd("cnt_l_ff", 8'h06, 8'hFF);
    rd("cnt_h_shadow", 8'h07, 8'h00);
    rd("cnt_l_103", 8'h06, 8'h03);
    rd("cnt_h_01", 8'h07, 8'h01);
    wr(8'h00, 8'h10);

    // Capture
    wr(8'h01, 8'h03);
    wr(8'h00, 8'h21);
    repeat (160) @(posedge clk);
    #1 ic = 1'b1;
    repeat (3) @(posedge clk);
    #1 ic = 1'b0;
    wr(8'h00, 8'h30);
`ifdef WB8_TC_CAPTURE_EN
    bus(1'b0, 8'h08, 8'h00, x);
    chk("cap_l_40_41", {15'b0, (x == 8'd40) || (x == 8'd41)}, 16'd1);
    rd("cap_h", 8'h09, 8'h00);
    rd("status_cap", 8'h0A, 8'h06);
    rd("ctrl_ie_cap", 8'h00, 8'h20);
    chk("int_cap", irq, 1'b1);
`else
    rd("cap_l_off", 8'h08, 8'h00);
    rd("cap_h_off", 8'h09, 8'h00);
    rd("status_nocap", 8'h0A, 8'h02);
    rd("ctrl_no_ie_cap", 8'h00, 8'h00);
    chk("int_nocap", irq, 1'b0);
`endif

    // Reset during an acked access drops ack at once
    @(posedge clk);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h01; dat_w = 8'h55;
    @(posedge clk); #1;
    chk("ack_before_rst", ack, 1'b1);
    #2 resetn = 1'b0;
    #1 chk("ack_async_rst", ack, 1'b0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk) resetn = 1'b1;
    rd("presc_after_rst", 8'h01, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
